// File: rtl/phase_ctrl_pkg.sv
// phase_ctrl_pkg: state encoding and phase codes shared by the sequencing controller.
package phase_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_STORE, S_HALT, S_ERR
  } ctrl_state_t;
  localparam logic [1:0] PH_FETCH  = 2'b00;
  localparam logic [1:0] PH_DECODE = 2'b01;
  localparam logic [1:0] PH_EXEC   = 2'b10;
  localparam logic [1:0] PH_STORE  = 2'b11;
endpackage

// File: rtl/phase_controller_wait_timer.sv
// wait_timer: clearable saturating memory wait counter; expired flags the last allowed wait cycle.
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);
  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && r_cnt != LIMIT) r_cnt <= r_cnt + W'(1);
  // TIMEOUT of 0 disables the time-out entirely
  assign o_expired = (TIMEOUT != 0) && (r_cnt == LIMIT);
endmodule

// File: rtl/phase_controller.sv
// phase_controller: multi-cycle instruction sequencer with memory handshake and time-out.
// Optional debug single-step mode is enabled by defining PHASE_CTRL_STEP_EN.
module phase_controller
  import phase_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             dbg_mode,
  input  logic             step,
  input  logic             is_halt,
  input  logic             needs_mem,
  input  logic             is_store,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_load,
  output logic             alu_en,
  output logic             reg_we,
  output logic             pc_inc,
  output logic [1:0]       phase,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count
);
  ctrl_state_t      r_state, w_next;
  logic             r_needs_mem, r_is_store;
  logic [CNT_W-1:0] r_count;
  logic             w_dbg, w_step, w_expired;
`ifdef PHASE_CTRL_STEP_EN
  assign w_dbg  = dbg_mode;
  assign w_step = step;
`else
  logic w_unused;
  assign w_unused = dbg_mode ^ step;
  assign w_dbg    = 1'b0;
  assign w_step   = 1'b0;
`endif
  wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (!mem_req || mem_ack),
    .i_inc    (mem_req && !mem_ack),
    .o_expired(w_expired)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state     <= S_IDLE;
      r_needs_mem <= 1'b0;
      r_is_store  <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_needs_mem <= needs_mem;
        r_is_store  <= is_store;
      end
      if (r_state == S_STORE) r_count <= r_count + CNT_W'(1);
    end
  always_comb begin
    w_next  = r_state;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_load = 1'b0;
    alu_en  = 1'b0;
    reg_we  = 1'b0;
    pc_inc  = 1'b0;
    phase   = PH_STORE;
    halted  = 1'b0;
    bus_err = 1'b0;
    case (r_state)
      S_IDLE:   w_next = (run && (!w_dbg || w_step)) ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ack;
        phase   = PH_FETCH;
        w_next  = mem_ack ? S_DECODE : w_expired ? S_ERR : S_FETCH;
      end
      S_DECODE: begin
        phase  = PH_DECODE;
        w_next = is_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        alu_en = 1'b1;
        phase  = PH_EXEC;
        w_next = r_needs_mem ? S_MEM : S_STORE;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = r_is_store;
        phase   = PH_EXEC;
        w_next  = mem_ack ? S_STORE : w_expired ? S_ERR : S_MEM;
      end
      S_STORE: begin
        pc_inc = 1'b1;
        reg_we = !r_is_store;
        w_next = (run && !w_dbg) ? S_FETCH : S_IDLE;
      end
      S_HALT:   halted  = 1'b1;
      S_ERR:    bus_err = 1'b1;
      default:  w_next  = S_IDLE;
    endcase
  end
  assign instr_count = r_count;
endmodule

// File: doc/phase_controller.md
# phase_controller

Sequencing controller for the multi-cycle CPU datapath. It steps each instruction through fetch, decode, execute, an optional memory phase and store. It drives the memory request/acknowledge handshake and emits per-phase control strobes (IR load, ALU enable, register write, PC increment). It also handles halt, bus time-out and an optional debug single-step mode. It sits between the instruction decoder and the datapath/memory port, and its 2-bit `phase` output keeps the existing phase encoding.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum wait cycles for `mem_ack` per memory phase; 0 disables the time-out.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `run`  in  1  level; 1 permits sequencing from IDLE.
- `dbg_mode`  in  1  single-step mode select (used only with `PHASE_CTRL_STEP_EN`).
- `step`  in  1  single-cycle pulse; releases one instruction in debug mode.
- `is_halt`  in  1  decoder flag; sampled in DECODE.
- `needs_mem`  in  1  decoder flag (load/store); sampled in DECODE.
- `is_store`  in  1  decoder flag; sampled in DECODE.
- `mem_ack`  in  1  memory acknowledge; may arrive in the same cycle as `mem_req`.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write enable; valid while `mem_req` = 1.
- `ir_load`  out  1  instruction register load strobe.
- `alu_en`  out  1  ALU operand/result capture.
- `reg_we`  out  1  register file write.
- `pc_inc`  out  1  PC increment.
- `phase`  out  2  00 fetch, 01 decode, 10 execute/mem, 11 store/idle.
- `halted`  out  1  halt reached.
- `bus_err`  out  1  memory time-out reached.
- `instr_count`  out  CNT_W  retired instructions; wraps modulo 2^CNT_W.

## Operation
States: IDLE, FETCH, DECODE, EXEC, MEM, STORE, HALT, ERR.

- **IDLE**: no strobes; `phase` = 11. Moves to FETCH when `run` = 1. In debug mode it requires `run` & `step`.
- **FETCH**: `mem_req` = 1, `mem_we` = 0.
  - On `mem_ack`: `ir_load` = 1 in that same cycle, then DECODE.
  - On time-out: ERR.
- **DECODE**: one cycle. Latches `needs_mem` and `is_store`.
  - `is_halt` = 1: HALT. The halt instruction does not increment `instr_count` or the PC.
  - Otherwise: EXEC.
- **EXEC**: `alu_en` = 1 for one cycle. Next state is MEM if latched `needs_mem`, else STORE.
- **MEM**: `mem_req` = 1, `mem_we` = latched `is_store`.
  - On `mem_ack`: STORE.
  - On time-out: ERR.
- **STORE**: `pc_inc` = 1, `instr_count` += 1, `reg_we` = !latched `is_store`.
  - Next state is FETCH if `run` = 1 and not in debug mode, else IDLE.
- **HALT**: `halted` = 1, no strobes. Exits only on reset.
- **ERR**: `bus_err` = 1, `mem_req` = 0. Exits only on reset.

Time-out rules:
- Wait counter clears on entry to FETCH and on entry to MEM.
- The counter increments each cycle `mem_req` = 1 and `mem_ack` = 0.
- When the count equals `TIMEOUT` and `mem_ack` = 0, the next state is ERR.
- If `mem_ack` = 1 in the time-out cycle, the ack wins.
- `run` deasserting mid-instruction does not abort the instruction; it completes through STORE, then goes to IDLE.

## Timing
- Reset (asynchronous, immediate): state = IDLE, all strobes 0, `phase` = 11, `halted` = 0, `bus_err` = 0, `instr_count` = 0, wait counter = 0, latched flags = 0.
- Reset asserted mid-memory access drops `mem_req` combinationally, without waiting for a clock edge.
- Strobes and `phase` are decoded from the current state. `ir_load` additionally depends on `mem_ack`.
- Zero-wait memory: a non-memory instruction takes 4 cycles (FETCH through STORE); a load/store takes 5.
- Each memory wait cycle adds one cycle.
- Back-to-back instructions: STORE is followed directly by FETCH with no bubble.
- `instr_count` updates on the clock edge leaving STORE.

## Configuration
- `PHASE_CTRL_STEP_EN` defined:
  - `dbg_mode` and `step` are active.
  - In debug mode, every instruction ends in IDLE and waits for the next `step` pulse.
  - A `step` arriving outside IDLE is ignored.
- Not defined:
  - `dbg_mode` and `step` are ignored (treated as 0).
  - The controller runs freely whenever `run` = 1.

## Structure
- Shared package `phase_ctrl_pkg`:
  - State enum `ctrl_state_t` (3-bit).
  - Phase encoding constants `PH_FETCH`, `PH_DECODE`, `PH_EXEC`, `PH_STORE`.
- Sub-module `wait_timer`: the clearable saturating wait counter. It is parameterised by `TIMEOUT` and outputs a `expired` flag.
- The FSM and strobe decode stay in `phase_controller`.

## Test plan
- **Reset then run, ack in the same cycle as req, ALU instruction**: `phase` sequence 00, 01, 10, 11, then 00. `ir_load` high in cycle 1, `pc_inc` and `reg_we` high in cycle 4, `instr_count` = 1.
- **Store instruction, MEM ack after 3 wait cycles**: `mem_we` = 1 for 4 cycles, `reg_we` = 0 in STORE, 8 cycles total.
- **`TIMEOUT` = 15, no ack in FETCH**: ERR after 16 FETCH cycles, `bus_err` = 1, `mem_req` = 0, state holds until reset.
- **Ack arrives exactly in the time-out cycle**: no error, proceeds to DECODE.
- **`is_halt` in DECODE**: `halted` = 1, `instr_count` unchanged, no `pc_inc`. Reset clears `halted` asynchronously.
- **With `PHASE_CTRL_STEP_EN`, `dbg_mode` = 1, three `step` pulses**: exactly 3 instructions retire, IDLE between each. Reset asserted mid-MEM returns all outputs to their reset values immediately.
